// File: rtl/md5_pkg.sv
// Shared constants and FSM encodings for the MD5 message buffer.
package md5_pkg;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam logic [5:0]  LEN_POS     = 6'd56;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned WORD_W      = 32;

    localparam logic [2:0] StFill  = 3'd0;
    localparam logic [2:0] StPad80 = 3'd1;
    localparam logic [2:0] StZero  = 3'd2;
    localparam logic [2:0] StLen   = 3'd3;
    localparam logic [2:0] StFull  = 3'd4;

endpackage

// File: rtl/md5_msg_buffer_if.sv
// Byte-stream input, block handshake and word read port of the MD5 message buffer.
interface md5_msg_buffer_if;
    import md5_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_last;
    logic              blk_valid;
    logic              blk_final;
    logic              blk_done;
    logic              read_en;
    logic [ADDR_W-1:0] address;
    logic [WORD_W-1:0] result;

    modport master (
        output in_valid, in_data, in_last, blk_done, read_en, address,
        input  in_ready, blk_valid, blk_final, result
    );

    modport slave (
        input  in_valid, in_data, in_last, blk_done, read_en, address,
        output in_ready, blk_valid, blk_final, result
    );

endinterface

// File: rtl/md5_word_ram.sv
// 16x32 simple dual-port RAM: one write port, one registered read port.
module md5_word_ram #(
    parameter int unsigned WORDS = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             read_en,
    input  logic [AW-1:0]    address,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] mem [WORDS];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (read_en) begin
            result <= mem[address];
        end
    end

endmodule

// File: rtl/md5_msg_buffer.sv
// Packs a byte stream little-endian into 512-bit MD5 blocks, adding 0x80/zero/length padding.
module md5_msg_buffer
    import md5_pkg::*;
#(
    parameter int unsigned WORDS = 16,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 64
) (
    input logic             clk,
    input logic             rst,
    md5_msg_buffer_if.slave bus
);

    logic [2:0]       state_q, state_d;
    logic [5:0]       pos_q, pos_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             len_pend_q, len_pend_d;
    logic             pad_pend_q, pad_pend_d;
    logic             final_q, final_d;
    logic             byte_we;
    logic [7:0]       byte_val;
    logic             ram_we;
    logic             accept;

    assign bus.in_ready  = (state_q == StFill) && !rst;
    assign bus.blk_valid = (state_q == StFull) && !rst;
    assign bus.blk_final = final_q && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign ram_we        = byte_we && (pos_q[1:0] == 2'd3);

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        word_d     = word_q;
        len_d      = len_q;
        len_pend_d = len_pend_q;
        pad_pend_d = pad_pend_q;
        final_d    = final_q;
        byte_we    = 1'b0;
        byte_val   = 8'h00;

        case (state_q)
            StFill: begin
                if (accept) begin
                    byte_we  = 1'b1;
                    byte_val = bus.in_data;
                    len_d    = len_q + LEN_W'(8);
                    // A last byte that fills the block defers the 0x80 to the next block.
                    if (bus.in_last && pos_q == 6'(BLOCK_BYTES - 1)) begin
                        state_d    = StFull;
                        pad_pend_d = 1'b1;
                    end else if (bus.in_last) begin
                        state_d = StPad80;
                    end else if (pos_q == 6'(BLOCK_BYTES - 1)) begin
                        state_d = StFull;
                    end
                end
            end
            StPad80: begin
                byte_we  = 1'b1;
                byte_val = PAD_BYTE;
            end
            StZero: begin
                byte_we = 1'b1;
            end
            StLen: begin
                byte_we  = 1'b1;
                byte_val = len_q[{pos_q[2:0], 3'b000} +: 8];
            end
            StFull: begin
                if (bus.blk_done) begin
                    final_d = 1'b0;
                    if (pad_pend_q) begin
                        state_d    = StPad80;
                        pad_pend_d = 1'b0;
                    end else if (len_pend_q) begin
                        state_d    = StZero;
                        len_pend_d = 1'b0;
                    end else begin
                        state_d = StFill;
                        if (final_q) begin
                            len_d = '0;
                        end
                    end
                end
            end
            default: state_d = StFill;
        endcase

        if (byte_we) begin
            word_d[{pos_q[1:0], 3'b000} +: 8] = byte_val;
            pos_d = pos_q + 6'd1;
            if (state_q == StLen) begin
                if (pos_q == 6'(BLOCK_BYTES - 1)) begin
                    state_d = StFull;
                    final_d = 1'b1;
                end
            end else if (state_q != StFill) begin
                // Padding steps on the position after this write.
                if (pos_d == LEN_POS) begin
                    state_d = StLen;
                end else if (pos_d == 6'd0) begin
                    state_d    = StFull;
                    len_pend_d = 1'b1;
                end else begin
                    state_d = StZero;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFill;
            pos_q      <= '0;
            word_q     <= '0;
            len_q      <= '0;
            len_pend_q <= 1'b0;
            pad_pend_q <= 1'b0;
            final_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            word_q     <= word_d;
            len_q      <= len_d;
            len_pend_q <= len_pend_d;
            pad_pend_q <= pad_pend_d;
            final_q    <= final_d;
        end
    end

    md5_word_ram #(
        .WORDS (WORDS),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we),
        .waddr   (pos_q[5:2]),
        .wdata   (word_d),
        .read_en (bus.read_en),
        .address (bus.address),
        .result  (bus.result)
    );

endmodule

// File: tb/tb_md5_msg_buffer.sv
// Directed bench for md5_msg_buffer: padded block contents, timing, back-pressure and reset.
module tb_md5_msg_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md5_msg_buffer_if bus();

    md5_msg_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       name;
        int unsigned nbytes;
        logic [7:0]  val;
        int unsigned nblk;
        logic        final0;
        logic [31:0] w0_0, w13_0, w14_0, w15_0;
        logic [31:0] w0_1, w13_1, w14_1, w15_1;
    } vec_t;

    vec_t        vecs [5];
    int          n_checks = 0;
    int          n_errors = 0;
    int          stalls   = 0;
    logic [31:0] blk_w [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        if (!bus.in_ready) stalls++;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_blk(output int n);
        n = 0;
        while (!bus.blk_valid && n < 300) begin
            tick();
            n++;
        end
        check("blk_valid_seen", 64'(bus.blk_valid), 64'd1);
    endtask

    task automatic read_blk();
        for (int i = 0; i < 16; i++) begin
            bus.read_en = 1'b1;
            bus.address = 4'(i);
            tick();
            blk_w[i] = bus.result;
        end
        bus.read_en = 1'b0;
    endtask

    task automatic release_blk();
        bus.blk_done = 1'b1;
        tick();
        bus.blk_done = 1'b0;
    endtask

    task automatic send_abc();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
    endtask

    initial begin
        int n;
        int busy;
        logic [31:0] exp;

        vecs[0] = '{"b55", 55, 8'h41, 1, 1'b1, 32'h41414141, 32'h80414141, 32'h000001B8, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1] = '{"b56", 56, 8'h41, 2, 1'b0, 32'h41414141, 32'h41414141, 32'h00000080, 32'h0,
                    32'h0, 32'h0, 32'h000001C0, 32'h0};
        vecs[2] = '{"b60", 60, 8'h41, 2, 1'b0, 32'h41414141, 32'h41414141, 32'h41414141,
                    32'h00000080, 32'h0, 32'h0, 32'h000001E0, 32'h0};
        vecs[3] = '{"b64", 64, 8'h41, 2, 1'b0, 32'h41414141, 32'h41414141, 32'h41414141,
                    32'h41414141, 32'h00000080, 32'h0, 32'h00000200, 32'h0};
        vecs[4] = '{"b1", 1, 8'h5A, 1, 1'b1, 32'h0000805A, 32'h0, 32'h00000008, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        bus.blk_done = 1'b0;
        bus.read_en  = 1'b0;
        bus.address  = 4'd0;
        rst          = 1'b1;
        tick();
        tick();

        // Reset values.
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_blk_valid", 64'(bus.blk_valid), 64'd0);
        check("rst_blk_final", 64'(bus.blk_final), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // "abc" with a byte held on the input throughout padding and FULL.
        send_abc();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        n    = 0;
        busy = 0;
        while (!bus.blk_valid && n < 300) begin
            if (bus.in_ready) busy++;
            tick();
            n++;
        end
        check("abc_blk_valid", 64'(bus.blk_valid), 64'd1);
        check("abc_latency", 64'(3 + n), 64'd64);
        for (int i = 0; i < 4; i++) begin
            if (bus.in_ready) busy++;
            tick();
        end
        check("ready_low_pad_full", 64'(busy), 64'd0);
        bus.in_valid = 1'b0;
        check("abc_final", 64'(bus.blk_final), 64'd1);
        read_blk();
        for (int i = 0; i < 16; i++) begin
            exp = (i == 0) ? 32'h80636261 : (i == 14) ? 32'h00000018 : 32'h0;
            check($sformatf("abc_w%0d", i), 64'(blk_w[i]), 64'(exp));
        end

        // Read latency: result changes exactly one edge after read_en.
        bus.read_en = 1'b1;
        bus.address = 4'd0;
        tick();
        bus.address = 4'd14;
        #1;
        check("rd_before_edge", 64'(bus.result), 64'h80636261);
        tick();
        check("rd_after_edge", 64'(bus.result), 64'h18);
        bus.read_en = 1'b0;
        bus.address = 4'd0;
        tick();
        check("rd_hold", 64'(bus.result), 64'h18);
        release_blk();
        check("abc_release_ready", 64'(bus.in_ready), 64'd1);

        // Table of message lengths around the padding boundaries.
        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < int'(vecs[v].nbytes); b++) begin
                send(vecs[v].val, b == int'(vecs[v].nbytes) - 1);
            end
            wait_blk(n);
            check({vecs[v].name, "_final0"}, 64'(bus.blk_final), 64'(vecs[v].final0));
            read_blk();
            check({vecs[v].name, "_b0w0"}, 64'(blk_w[0]), 64'(vecs[v].w0_0));
            check({vecs[v].name, "_b0w13"}, 64'(blk_w[13]), 64'(vecs[v].w13_0));
            check({vecs[v].name, "_b0w14"}, 64'(blk_w[14]), 64'(vecs[v].w14_0));
            check({vecs[v].name, "_b0w15"}, 64'(blk_w[15]), 64'(vecs[v].w15_0));
            release_blk();
            if (vecs[v].nblk == 2) begin
                wait_blk(n);
                check({vecs[v].name, "_final1"}, 64'(bus.blk_final), 64'd1);
                read_blk();
                check({vecs[v].name, "_b1w0"}, 64'(blk_w[0]), 64'(vecs[v].w0_1));
                check({vecs[v].name, "_b1w7"}, 64'(blk_w[7]), 64'd0);
                check({vecs[v].name, "_b1w13"}, 64'(blk_w[13]), 64'(vecs[v].w13_1));
                check({vecs[v].name, "_b1w14"}, 64'(blk_w[14]), 64'(vecs[v].w14_1));
                check({vecs[v].name, "_b1w15"}, 64'(blk_w[15]), 64'(vecs[v].w15_1));
                release_blk();
            end
            check({vecs[v].name, "_ready_after"}, 64'(bus.in_ready), 64'd1);
        end

        // Reset after 20 bytes, then a clean "abc".
        for (int b = 0; b < 20; b++) send(8'h33, 1'b0);
        rst = 1'b1;
        tick();
        check("midrst_in_ready_low", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_blk_valid", 64'(bus.blk_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        send_abc();
        wait_blk(n);
        check("midrst_final", 64'(bus.blk_final), 64'd1);
        read_blk();
        check("midrst_w0", 64'(blk_w[0]), 64'h80636261);
        check("midrst_w1", 64'(blk_w[1]), 64'h0);
        check("midrst_w14", 64'(blk_w[14]), 64'h18);
        check("midrst_w15", 64'(blk_w[15]), 64'h0);

        // Reset while FULL.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("fullrst_blk_valid", 64'(bus.blk_valid), 64'd0);
        check("fullrst_blk_final", 64'(bus.blk_final), 64'd0);
        check("fullrst_in_ready", 64'(bus.in_ready), 64'd1);

        check("send_stalls", 64'(stalls), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
